uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART byte transmitter between NUM_REQ byte sources.
- Arbitrates requests and latches the winner's byte. Issues a one-cycle write strobe to the transmitter and waits for the frame to finish.
- Enforces a configurable inter-byte gap, counted in baud ticks.
- Optional per-requester LOCK keeps the grant across back-to-back bytes (packet mode).

---
 rtl/uart_sched_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and its round-robin picker.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_CHAIN     = 3'd4
  } state_t;

  localparam int GAP_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  // Scan farthest-first so the nearest request (from ptr_i) overwrites last.
  always_comb begin
    logic [IDX_W-1:0] j;
    j     = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) begin
        idx_o = j;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ sources,
// with inter-byte gap in baud ticks and per-requester packet lock.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int GAP_TICKS = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [NUM_REQ-1:0]     LOCK,
  input  logic [8*NUM_REQ-1:0]   DATA,
  output logic [NUM_REQ-1:0]     ACK,
  output logic [IDX_W-1:0]       GRANT_ID,
  output logic                   BUSY,
  output logic [7:0]             TX_DATA,
  output logic                   TX_WE,
  input  logic                   TX_READY,
  input  logic                   BAUD_EN
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [7:0]       txd_q, txd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             blank_q, blank_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (rr_q),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      txd_q   <= 8'h00;
      gap_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      txd_q   <= txd_d;
      gap_q   <= gap_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    txd_d   = txd_q;
    gap_d   = gap_q;
    blank_d = 1'b0;
    TX_WE   = 1'b0;
    ACK     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ENABLE && win_vld) begin
          state_d = S_LOAD;
          gid_d   = win_idx;
          txd_d   = DATA[8*int'(win_idx) +: 8];
          rr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
        end
      end
      S_LOAD: begin
        if (TX_READY) begin
          TX_WE       = 1'b1;
          ACK[gid_q]  = 1'b1;
          state_d     = S_WAIT_DONE;
          blank_d     = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // First cycle after the strobe: the transmitter may not have dropped READY yet.
        if (!blank_q && TX_READY) begin
          if (GAP_TICKS > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_TICKS);
          end else begin
            state_d = S_CHAIN;
          end
        end
      end
      S_GAP: begin
        if (BAUD_EN) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) state_d = S_CHAIN;
        end
      end
      S_CHAIN: begin
        // Locked packet keeps the grant and the rr pointer; ENABLE is not consulted.
        if (LOCK[gid_q] && REQ[gid_q]) begin
          txd_d   = DATA[8*int'(gid_q) +: 8];
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign GRANT_ID = gid_q;
  assign TX_DATA  = txd_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset, round-robin, lock, gap, backpressure, enable.
module tb_uart_tx_sched;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b1;
  logic [3:0]  REQ = '0, LOCK = '0;
  logic [31:0] DATA = '0;
  logic [3:0]  ACK;
  logic [1:0]  GRANT_ID;
  logic        BUSY, TX_WE;
  logic [7:0]  TX_DATA;
  logic        TX_READY = 1'b1, BAUD_EN = 1'b0;

  logic        g_ENABLE = 1'b1;
  logic [3:0]  g_REQ = '0, g_LOCK = '0;
  logic [31:0] g_DATA = '0;
  logic [3:0]  g_ACK;
  logic [1:0]  g_GRANT_ID;
  logic        g_BUSY, g_TX_WE;
  logic [7:0]  g_TX_DATA;
  logic        g_TX_READY = 1'b1, g_BAUD_EN = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_sched #(.NUM_REQ(4), .IDX_W(2), .GAP_TICKS(0)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .REQ(REQ), .LOCK(LOCK), .DATA(DATA),
    .ACK(ACK), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .TX_DATA(TX_DATA), .TX_WE(TX_WE),
    .TX_READY(TX_READY), .BAUD_EN(BAUD_EN)
  );

  uart_tx_sched #(.NUM_REQ(4), .IDX_W(2), .GAP_TICKS(3)) dut_gap (
    .CLK(CLK), .RESET(RESET), .ENABLE(g_ENABLE), .REQ(g_REQ), .LOCK(g_LOCK), .DATA(g_DATA),
    .ACK(g_ACK), .GRANT_ID(g_GRANT_ID), .BUSY(g_BUSY), .TX_DATA(g_TX_DATA), .TX_WE(g_TX_WE),
    .TX_READY(g_TX_READY), .BAUD_EN(g_BAUD_EN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until TX_WE is seen (bounded); check the strobe and the cycle count.
  task automatic wait_we(input string tag, input int exp_cnt);
    int n;
    n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while (!TX_WE && n < 100);
    chk({tag, "_we"}, 32'(TX_WE), 32'd1);
    chk({tag, "_lat"}, n, exp_cnt);
  endtask

  // Transmitter model: READY low for n cycles, then high again.
  task automatic xmit(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); TX_READY = 1'b0;
    end
    @(negedge CLK); TX_READY = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int wes;
    // Reset values
    idle(2); #1;
    chk("rst_we", 32'(TX_WE), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_gid", 32'(GRANT_ID), 0);
    chk("rst_txd", 32'(TX_DATA), 0);

    // Reset asserted while stalled in LOAD
    @(negedge CLK);
    RESET = 1'b0; REQ = 4'b0010; TX_READY = 1'b0; DATA = 32'h0000_C100;
    @(negedge CLK); #1;
    chk("load_busy", 32'(BUSY), 1);
    chk("load_gid", 32'(GRANT_ID), 1);
    chk("load_txd", 32'(TX_DATA), 32'hC1);
    chk("load_we", 32'(TX_WE), 0);
    @(negedge CLK);
    TX_READY = 1'b1; RESET = 1'b1; #1;
    chk("midrst_we", 32'(TX_WE), 0);
    chk("midrst_ack", 32'(ACK), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_gid", 32'(GRANT_ID), 0);
    chk("midrst_txd", 32'(TX_DATA), 0);
    @(negedge CLK); RESET = 1'b0;
    wait_we("postrst", 1);
    chk("postrst_ack", 32'(ACK), 32'b0010);
    chk("postrst_gid", 32'(GRANT_ID), 1);
    REQ = 4'b0000;
    xmit(4);
    idle(3); #1;
    chk("postrst_idle", 32'(BUSY), 0);

    // Lock: rr pointer is 2, requester 2 sends a 3-byte packet ahead of requester 0
    @(negedge CLK);
    REQ = 4'b0101; LOCK = 4'b0100; DATA = 32'h0011_0055;
    wait_we("lock1", 1);
    chk("lock1_txd", 32'(TX_DATA), 32'h11);
    chk("lock1_ack", 32'(ACK), 32'b0100);
    DATA = 32'h0022_0055;
    xmit(4);
    wait_we("lock2", 2);
    chk("lock2_txd", 32'(TX_DATA), 32'h22);
    chk("lock2_ack", 32'(ACK), 32'b0100);
    DATA = 32'h0033_0055;
    xmit(4);
    wait_we("lock3", 2);
    chk("lock3_txd", 32'(TX_DATA), 32'h33);
    chk("lock3_gid", 32'(GRANT_ID), 2);
    // Pointer must be 3 now: with requesters 0 and 3 pending, 3 wins
    REQ = 4'b1001; LOCK = 4'b0000; DATA = 32'h7700_0055;
    xmit(4);
    wait_we("lockrr", 3);
    chk("lockrr_gid", 32'(GRANT_ID), 3);
    chk("lockrr_txd", 32'(TX_DATA), 32'h77);
    chk("lockrr_ack", 32'(ACK), 32'b1000);
    REQ = 4'b0000;
    xmit(4);
    idle(3);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;

    // Round-robin fairness with all requesters active
    @(negedge CLK);
    REQ = 4'b1111; DATA = 32'hA3A2_A1A0; #1;
    chk("rr_idle_we", 32'(TX_WE), 0);
    for (int k = 0; k < 5; k++) begin
      wait_we($sformatf("rr%0d", k), (k == 0) ? 1 : 3);
      chk($sformatf("rr%0d_txd", k), 32'(TX_DATA), 32'hA0 + 32'(k % 4));
      chk($sformatf("rr%0d_ack", k), 32'(ACK), 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_gid", k), 32'(GRANT_ID), 32'(k % 4));
      if (k == 4) REQ = 4'b0000;
      xmit(10);
    end
    idle(3);

    // Backpressure: READY low 20 cycles in LOAD, pointer is 1
    @(negedge CLK);
    TX_READY = 1'b0; REQ = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      chk("bp_hold", {27'd0, TX_WE, ACK}, 32'd0);
    end
    @(negedge CLK);
    TX_READY = 1'b1; #1;
    chk("bp_we", 32'(TX_WE), 1);
    chk("bp_ack", 32'(ACK), 32'b0010);
    chk("bp_txd", 32'(TX_DATA), 32'hA1);
    REQ = 4'b0000;
    @(negedge CLK); #1;
    chk("bp_single", {27'd0, TX_WE, ACK}, 32'd0);
    // READY left high: blanking cycle delays completion by one cycle
    @(negedge CLK); #1;
    chk("blank_busy1", 32'(BUSY), 1);
    @(negedge CLK); #1;
    chk("blank_busy2", 32'(BUSY), 1);
    @(negedge CLK); #1;
    chk("blank_idle", 32'(BUSY), 0);

    // ENABLE drop during WAIT_DONE, pointer is 2
    @(negedge CLK);
    REQ = 4'b0011;
    wait_we("en0", 1);
    chk("en0_ack", 32'(ACK), 32'b0001);
    chk("en0_txd", 32'(TX_DATA), 32'hA0);
    @(negedge CLK); ENABLE = 1'b0;
    xmit(3);
    wes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      wes += int'(TX_WE);
    end
    chk("en_off_we", wes, 0);
    chk("en_off_busy", 32'(BUSY), 0);
    @(negedge CLK); ENABLE = 1'b1;
    wait_we("en1", 1);
    chk("en1_ack", 32'(ACK), 32'b0010);
    chk("en1_txd", 32'(TX_DATA), 32'hA1);
    REQ = 4'b0000;
    xmit(3);
    idle(3);

    // Gap of 3 baud ticks on the second instance, locked packet of two bytes
    @(negedge CLK);
    g_REQ = 4'b0001; g_LOCK = 4'b0001; g_DATA = 32'h0000_005A; #1;
    chk("gap_idle_we", 32'(g_TX_WE), 0);
    @(negedge CLK); #1;
    chk("gap1_we", 32'(g_TX_WE), 1);
    chk("gap1_ack", 32'(g_ACK), 32'b0001);
    chk("gap1_gid", 32'(g_GRANT_ID), 0);
    chk("gap1_txd", 32'(g_TX_DATA), 32'h5A);
    g_DATA = 32'h0000_005B;
    @(negedge CLK); g_TX_READY = 1'b0;
    // BAUD_EN coincides with entry to GAP and must not count
    @(negedge CLK); g_TX_READY = 1'b1; g_BAUD_EN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      g_BAUD_EN = (k == 1 || k == 3 || k == 5);
      #1;
      chk($sformatf("gap_we_k%0d", k), 32'(g_TX_WE), 32'(k == 7));
      chk($sformatf("gap_busy_k%0d", k), 32'(g_BUSY), 1);
    end
    chk("gap2_txd", 32'(g_TX_DATA), 32'h5B);
    g_REQ = 4'b0000; g_LOCK = 4'b0000;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
